bus_rr_scheduler: RTL
=====================

# bus_rr_scheduler

Single-bus round-robin scheduler that shares one data bus among `drvrs` source FIFOs and routes each packet to the destination FIFOs. It sits between the driver-side FIFO array and the receiver-side FIFO array, in the position of the bus generator/arbiter. It uses the same `pndng`/`pop`/`D_pop`/`push`/`D_push` handshake, so the existing FIFO interface connects without change. Each packet carries its destination ID in the upper 8 bits; the ID `broadcast` delivers the packet to every driver except the source.

## Interface
- `drvrs`, 4: number of source/destination FIFOs; legal range 2..255.
- `pckg_sz`, 16: packet width in bits; must be greater than 8.
- `broadcast`, 8'hFF: destination ID that selects broadcast delivery.

- `clk` in, 1: the single clock.
- `reset` in, 1: asynchronous, active-low; 0 clears all state immediately.
- `pndng` in, [drvrs-1:0]: source FIFO i is non-empty. `D_pop[i]` is valid while `pndng[i]` is high (show-ahead FIFO).
- `D_pop` in, [drvrs-1:0][pckg_sz-1:0]: head packet of each source FIFO.
- `pop` out, [drvrs-1:0]: one-cycle pop strobe to source FIFO i.
- `push` out, [drvrs-1:0]: one-cycle push strobe to destination FIFO i.
- `D_push` out, [drvrs-1:0][pckg_sz-1:0]: packet to destination FIFOs. All lanes carry the same value.
- `busy` out, 1: high whenever the scheduler is outside the IDLE state.
- `drop_cnt` out, 16: saturating count of dropped packets.

## Operation
- Destination ID: `dst = pkt[pckg_sz-1 -: 8]`.
- FSM states:
  - IDLE: when `|pndng` is high, latch the round-robin winner `g`, then go to POP.
  - POP: `pop[g]=1` for exactly one cycle; capture `D_pop[g]` into `pkt_q`. If `pndng[g]` is found low, abort to IDLE with no pop and no drop. Otherwise go to PUSH.
  - PUSH: set the `push` mask for one cycle, drive `D_push[*]=pkt_q`, then go to IDLE.
- Round-robin arbitration:
  - The search starts at `last_g+1` modulo `drvrs`; the lowest index at or after that point with `pndng` set wins.
  - `last_g` updates on entry to POP.
  - `last_g` resets to `drvrs-1`, so driver 0 has first priority after reset.
- Push mask:
  - `dst < drvrs` and `dst != g`: `push[dst]=1`.
  - `dst == broadcast`: `push = ~(1<<g)`.
  - `dst == g` (self-addressed), or `dst >= drvrs` and not broadcast: `push = 0` and `drop_cnt` increments.
- `drop_cnt` saturates at 16'hFFFF and never wraps.
- Requests that change during POP or PUSH do not affect the packet in flight; they are evaluated at the next IDLE.

## Timing
- All outputs are registered.
- Reset values: `pop=0`, `push=0`, `D_push=0`, `busy=0`, `drop_cnt=0`, state=IDLE, `last_g=drvrs-1`, `pkt_q=0`.
- Latency: `pndng` sampled high at edge N gives `pop` high in cycle N+1 and `push` high in cycle N+2.
- Throughput: one packet per 3 cycles. IDLE always lasts at least one cycle between packets.
- `pop` and `push` are never high in the same cycle.
- At most one `pop` bit is high in any cycle.
- Reset asserted mid-operation:
  - Outputs clear asynchronously.
  - A packet already popped and not yet pushed is lost and is not counted as a drop.
  - First arbitration occurs on the first rising edge after `reset` goes high.
- Destination-FIFO full is not visible to this block; overflow handling belongs to the FIFO.

## Structure
- Package `bus_sched_pkg`:
  - state enum `{IDLE, POP, PUSH}`.
  - constants `ID_W=8` and `DEF_BROADCAST=8'hFF`.
  - function `dst_of(pkt)`.
- Sub-module `rr_picker #(drvrs)`: combinational. Inputs `req`, `last_g`; outputs `gnt_idx`, `any`. Contains the rotate-and-priority-encode logic.
- Top level: FSM, `pkt_q`, push-mask decode, `drop_cnt`.

## Test plan
- Single unicast: `pndng=4'b0001`, `D_pop[0]=16'h02AB`.
  - `pop=4'b0001` at N+1.
  - `push=4'b0100` and `D_push[2]=16'h02AB` at N+2.
  - `drop_cnt=0`.
- Round-robin fairness: `pndng=4'b1111` held for 4 packets.
  - Grant order is 0,1,2,3, then 0 again.
  - No driver is granted twice before all others have been served.
- Broadcast: driver 1 sends 16'hFF55.
  - `push=4'b1101`, all lanes equal 16'hFF55.
- Drops: driver 0 sends 16'h0711 (ID 7 ≥ 4), then driver 3 sends 16'h0322 (self-addressed).
  - No push for either packet.
  - `drop_cnt=2`.
- Reset mid-packet: assert `reset=0` during the PUSH cycle.
  - `push`, `busy` and `drop_cnt` go to 0 immediately.
  - After release, driver 0 is granted first.
- Withdrawn request: `pndng[g]` falls during POP.
  - Scheduler returns to IDLE with no pop, no push and `drop_cnt` unchanged.

Source files
------------

// File: rtl/bus_sched_pkg.sv
// Shared types and constants for the single-bus round-robin scheduler.
package bus_sched_pkg;

    localparam int unsigned ID_W      = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned PKT_MAX_W = 1024;

    localparam logic [ID_W-1:0] DEF_BROADCAST = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_e;

    // Destination ID lives in the top ID_W bits of a pkt_w-bit packet.
    function automatic logic [ID_W-1:0] dst_of(input logic [PKT_MAX_W-1:0] pkt,
                                               input int unsigned         pkt_w);
        return ID_W'(pkt >> (pkt_w - ID_W));
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester strictly after last_g, wrapping at drvrs.
module rr_picker #(
    parameter int unsigned drvrs = 4
) (
    input  logic [drvrs-1:0]          req,
    input  logic [$clog2(drvrs)-1:0]  last_g,
    output logic [$clog2(drvrs)-1:0]  gnt_idx,
    output logic                      any
);

    localparam int unsigned IDX_W = $clog2(drvrs);
    localparam int unsigned SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] pos;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        pos     = '0;
        for (int k = int'(drvrs); k > 0; k--) begin
            pos = SUM_W'(last_g) + SUM_W'(k);
            if (pos >= SUM_W'(drvrs)) begin
                pos = pos - SUM_W'(drvrs);
            end
            if (req[pos[IDX_W-1:0]]) begin
                gnt_idx = pos[IDX_W-1:0];
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Shares one packet bus among drvrs source FIFOs, round-robin, and routes each
// packet to the destination FIFO(s) named by its ID byte.
module bus_rr_scheduler
    import bus_sched_pkg::*;
#(
    parameter int unsigned     drvrs     = 4,
    parameter int unsigned     pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = DEF_BROADCAST
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [drvrs-1:0]              pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]              pop,
    output logic [drvrs-1:0]              push,
    output logic [drvrs-1:0][pckg_sz-1:0] D_push,
    output logic                          busy,
    output logic [CNT_W-1:0]              drop_cnt
);

    localparam int unsigned IDX_W = $clog2(drvrs);

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                g_q, g_d;
    logic [IDX_W-1:0]                last_g_q, last_g_d;
    logic [pckg_sz-1:0]              pkt_q, pkt_d;
    logic [drvrs-1:0]                pop_q, pop_d;
    logic [drvrs-1:0]                push_q, push_d;
    logic [drvrs-1:0][pckg_sz-1:0]   d_push_q, d_push_d;
    logic                            busy_q, busy_d;
    logic [CNT_W-1:0]                drop_q, drop_d;

    logic [IDX_W-1:0]                gnt_idx;
    logic                            any_req;
    logic [ID_W-1:0]                 dst;
    logic [drvrs-1:0]                push_mask_c;
    logic                            drop_c;

    rr_picker #(.drvrs(drvrs)) u_pick (
        .req     (pndng),
        .last_g  (last_g_q),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    // Destination decode for the packet held in pkt_q; self-addressed and unknown IDs drop.
    always_comb begin
        dst         = dst_of(PKT_MAX_W'(pkt_q), pckg_sz);
        push_mask_c = '0;
        drop_c      = 1'b0;
        if (dst == broadcast) begin
            push_mask_c      = '1;
            push_mask_c[g_q] = 1'b0;
        end else if ((32'(dst) < drvrs) && (dst != ID_W'(g_q))) begin
            push_mask_c[dst[IDX_W-1:0]] = 1'b1;
        end else begin
            drop_c = 1'b1;
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        last_g_d = last_g_q;
        pkt_d    = pkt_q;
        pop_d    = '0;
        push_d   = '0;
        d_push_d = d_push_q;
        drop_d   = drop_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    g_d      = gnt_idx;
                    last_g_d = gnt_idx;
                    state_d  = POP;
                end
            end
            POP: begin
                if (pndng[g_q]) begin
                    pop_d[g_q] = 1'b1;
                    pkt_d      = D_pop[g_q];
                    state_d    = PUSH;
                end else begin
                    state_d = IDLE;
                end
            end
            PUSH: begin
                push_d   = push_mask_c;
                d_push_d = {drvrs{pkt_q}};
                if (drop_c && (drop_q != '1)) begin
                    drop_d = drop_q + CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            g_q      <= '0;
            last_g_q <= IDX_W'(drvrs - 1);
            pkt_q    <= '0;
            pop_q    <= '0;
            push_q   <= '0;
            d_push_q <= '0;
            busy_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            last_g_q <= last_g_d;
            pkt_q    <= pkt_d;
            pop_q    <= pop_d;
            push_q   <= push_d;
            d_push_q <= d_push_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = d_push_q;
    assign busy     = busy_q;
    assign drop_cnt = drop_q;

endmodule
